// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared encodings for the ALU sequencer.
//   - request opcodes carried on req*_op
//   - ALU opcodes driven on alu_op
//   - sequencer FSM state enum
// Optional feature macro: ALU_SEQ_SUB_EN (two-pass SUB sequencing; without it
// op 10 is reported as illegal and the EXEC2/CAPT2 states do not exist).
package alu_seq_pkg;

  // Request operation encodings
  localparam logic [1:0] REQ_OP_ADD = 2'b00;
  localparam logic [1:0] REQ_OP_NOT = 2'b01;
  localparam logic [1:0] REQ_OP_SUB = 2'b10;
  localparam logic [1:0] REQ_OP_ILL = 2'b11;

  // ALU opcodes
  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_NOT = 3'b001;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_RESP  = 3'd3
`ifdef ALU_SEQ_SUB_EN
    ,
    ST_EXEC2 = 3'd4,
    ST_CAPT2 = 3'd5
`endif
  } state_e;

  // True when the request op can be executed in this build
  function automatic logic op_is_legal(input logic [1:0] op);
`ifdef ALU_SEQ_SUB_EN
    return (op != REQ_OP_ILL);
`else
    return (op != REQ_OP_ILL) && (op != REQ_OP_SUB);
`endif
  endfunction

endpackage : alu_seq_pkg

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req[1:0]    request vector, bit i = requester i
//   update      commit the current grant as the new last_grant
//   grant[1:0]  one-hot (or zero) grant, combinational from req/last_grant
// last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  // On a tie the requester not granted last time wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner only when its handshake completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant[1];
    end
  end

endmodule : rr_arb2

// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one registered N-bit ALU (adder + NOT) between two
// requesters, arbitrating round-robin and sequencing two-pass subtraction.
// Optional feature macro: ALU_SEQ_SUB_EN (SUB = a + ~b + 1 over two ALU
// passes; without it op 10 returns rsp_err=1 and result 0).
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid[1:0]/req_ready[1:0] request handshakes (req_ready comb, IDLE only)
//   req{0,1}_a/_b/_op/_cin        request operands, op and carry-in
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/result/cout/err        response payload, held until rsp_ready
//   alu_a/alu_b/alu_cin/alu_op    ALU operand/opcode drive (registered)
//   alu_result/alu_cout           ALU registered result and carry
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req0_cin,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [1:0]   req1_op,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_cout,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_cout
);

  state_e       state, state_nxt;

  logic [1:0]   grant;
  logic         accept;
  logic         win_id;
  logic [N-1:0] win_a, win_b;
  logic [1:0]   win_op;
  logic         win_cin;

  logic [1:0]   op_q, op_nxt;
  logic         id_q, id_nxt;
`ifdef ALU_SEQ_SUB_EN
  logic [N-1:0] a_q, a_nxt;
`endif

  logic         rsp_valid_nxt;
  logic         rsp_id_nxt;
  logic [N-1:0] rsp_result_nxt;
  logic         rsp_cout_nxt;
  logic         rsp_err_nxt;
  logic [N-1:0] alu_a_nxt, alu_b_nxt;
  logic         alu_cin_nxt;
  logic [2:0]   alu_op_nxt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .update (accept),
    .grant  (grant)
  );

  // Offer the grant only while idle and out of reset
  assign req_ready = (rst_n && (state == ST_IDLE)) ? grant : 2'b00;
  assign accept    = |req_ready;

  // Winner's request fields
  assign win_id  = grant[1];
  assign win_a   = win_id ? req1_a   : req0_a;
  assign win_b   = win_id ? req1_b   : req0_b;
  assign win_op  = win_id ? req1_op  : req0_op;
  assign win_cin = win_id ? req1_cin : req0_cin;

  // Next-state and next-output logic. The ALU drive registers are loaded
  // on the edge entering EXEC/EXEC2 so the ALU samples them on the edge
  // leaving that state; everywhere else they fall back to ADD with zeros.
  always_comb begin
    state_nxt      = state;
    op_nxt         = op_q;
    id_nxt         = id_q;
`ifdef ALU_SEQ_SUB_EN
    a_nxt          = a_q;
`endif
    rsp_valid_nxt  = rsp_valid;
    rsp_id_nxt     = rsp_id;
    rsp_result_nxt = rsp_result;
    rsp_cout_nxt   = rsp_cout;
    rsp_err_nxt    = rsp_err;
    alu_a_nxt      = '0;
    alu_b_nxt      = '0;
    alu_cin_nxt    = 1'b0;
    alu_op_nxt     = ALU_OP_ADD;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          id_nxt = win_id;
          op_nxt = win_op;
`ifdef ALU_SEQ_SUB_EN
          a_nxt  = win_a;
`endif
          if (!op_is_legal(win_op)) begin
            // Illegal/disabled op skips the ALU entirely
            state_nxt      = ST_RESP;
            rsp_valid_nxt  = 1'b1;
            rsp_id_nxt     = win_id;
            rsp_result_nxt = '0;
            rsp_cout_nxt   = 1'b0;
            rsp_err_nxt    = 1'b1;
          end else begin
            state_nxt = ST_EXEC;
            case (win_op)
              REQ_OP_ADD: begin
                alu_op_nxt  = ALU_OP_ADD;
                alu_a_nxt   = win_a;
                alu_b_nxt   = win_b;
                alu_cin_nxt = win_cin;
              end
              REQ_OP_NOT: begin
                alu_op_nxt = ALU_OP_NOT;
                alu_a_nxt  = win_a;
              end
              default: begin
                // SUB pass 1: invert b
                alu_op_nxt = ALU_OP_NOT;
                alu_a_nxt  = win_b;
              end
            endcase
          end
        end
      end

      ST_EXEC: state_nxt = ST_CAPT;

      ST_CAPT: begin
`ifdef ALU_SEQ_SUB_EN
        if (op_q == REQ_OP_SUB) begin
          // SUB pass 2: a + nb + 1; alu_b carries nb through EXEC2
          state_nxt   = ST_EXEC2;
          alu_op_nxt  = ALU_OP_ADD;
          alu_a_nxt   = a_q;
          alu_b_nxt   = alu_result;
          alu_cin_nxt = 1'b1;
        end else
`endif
        begin
          state_nxt      = ST_RESP;
          rsp_valid_nxt  = 1'b1;
          rsp_id_nxt     = id_q;
          rsp_result_nxt = alu_result;
          rsp_cout_nxt   = (op_q == REQ_OP_NOT) ? 1'b0 : alu_cout;
          rsp_err_nxt    = 1'b0;
        end
      end

`ifdef ALU_SEQ_SUB_EN
      ST_EXEC2: state_nxt = ST_CAPT2;

      ST_CAPT2: begin
        state_nxt      = ST_RESP;
        rsp_valid_nxt  = 1'b1;
        rsp_id_nxt     = id_q;
        rsp_result_nxt = alu_result;
        rsp_cout_nxt   = alu_cout;
        rsp_err_nxt    = 1'b0;
      end
`endif

      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= REQ_OP_ADD;
      id_q       <= 1'b0;
`ifdef ALU_SEQ_SUB_EN
      a_q        <= '0;
`endif
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_op     <= ALU_OP_ADD;
    end else begin
      state      <= state_nxt;
      op_q       <= op_nxt;
      id_q       <= id_nxt;
`ifdef ALU_SEQ_SUB_EN
      a_q        <= a_nxt;
`endif
      rsp_valid  <= rsp_valid_nxt;
      rsp_id     <= rsp_id_nxt;
      rsp_result <= rsp_result_nxt;
      rsp_cout   <= rsp_cout_nxt;
      rsp_err    <= rsp_err_nxt;
      alu_a      <= alu_a_nxt;
      alu_b      <= alu_b_nxt;
      alu_cin    <= alu_cin_nxt;
      alu_op     <= alu_op_nxt;
    end
  end

endmodule : alu_sequencer

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer (N=8) with a
// behavioural ALU and a transaction-level reference model.
// Honours ALU_SEQ_SUB_EN the same way as the design.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam int unsigned N = 8;
`ifdef ALU_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [N-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_err;
  logic [N-1:0] alu_a, alu_b;
  logic         alu_cin;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_result = '0;
  logic         alu_cout = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  alu_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Registered ALU: opcode 001 is NOT, anything else adds
  always @(posedge clk) begin
    if (alu_op == 3'b001) begin
      alu_result <= ~alu_a;
      alu_cout   <= 1'b0;
    end else begin
      {alu_cout, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: expected response fields and latency (cycles from accept)
  function automatic void model_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                     input logic cin, output logic [7:0] r, output logic co,
                                     output logic er, output int lat);
    logic [8:0] s;
    r = 8'h00; co = 1'b0; er = 1'b0; lat = 3;
    if (op == 2'b00) begin
      s = {1'b0, a} + {1'b0, b} + 9'(cin);
      r = s[7:0]; co = s[8];
    end else if (op == 2'b01) begin
      r = ~a;
    end else if (op == 2'b10 && SUB_EN) begin
      r = a - b; co = (a >= b); lat = 5;
    end else begin
      er = 1'b1; lat = 1;
    end
  endfunction

  // Model state
  bit         busy = 1'b0;
  bit         m_last = 1'b1;
  int         acc_c;
  int         m_id;
  logic [1:0] m_op;
  logic [7:0] m_a, m_b;
  logic       m_cin;
  logic [7:0] e_r;
  logic       e_co, e_er;
  int         e_lat;
  int         acc_ids[$];
  int         acc_cycs[$];
  bit         acc_flag[2];

  logic [1:0] c_ready;
  logic       c_ev;
  logic [7:0] c_ea, c_eb;
  logic       c_ec;
  logic [2:0] c_eo;

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      busy   = 1'b0;
      m_last = 1'b1;
    end else begin
      if (busy)                   c_ready = 2'b00;
      else if (req_valid == 2'b11) c_ready = m_last ? 2'b01 : 2'b10;
      else                        c_ready = req_valid;
      check("req_ready", 32'(req_ready), 32'(c_ready));

      c_ev = busy && (cyc >= acc_c + e_lat);
      check("rsp_valid", 32'(rsp_valid), 32'(c_ev));
      if (c_ev) begin
        check("rsp_id",     32'(rsp_id),     32'(m_id));
        check("rsp_result", 32'(rsp_result), 32'(e_r));
        check("rsp_cout",   32'(rsp_cout),   32'(e_co));
        check("rsp_err",    32'(rsp_err),    32'(e_er));
      end

      c_ea = 8'h00; c_eb = 8'h00; c_ec = 1'b0; c_eo = 3'b000;
      if (busy && !e_er && cyc == acc_c + 1) begin
        if (m_op == 2'b00) begin c_ea = m_a; c_eb = m_b; c_ec = m_cin; end
        else if (m_op == 2'b01) begin c_ea = m_a; c_eo = 3'b001; end
        else begin c_ea = m_b; c_eo = 3'b001; end
      end
      if (busy && !e_er && m_op == 2'b10 && cyc == acc_c + 3) begin
        c_ea = m_a; c_eb = ~m_b; c_ec = 1'b1;
      end
      check("alu_a",   32'(alu_a),   32'(c_ea));
      check("alu_b",   32'(alu_b),   32'(c_eb));
      check("alu_cin", 32'(alu_cin), 32'(c_ec));
      check("alu_op",  32'(alu_op),  32'(c_eo));

      if (c_ev && rsp_ready) begin
        busy = 1'b0;
      end else if (!busy && c_ready != 2'b00) begin
        m_id  = c_ready[1] ? 1 : 0;
        m_op  = m_id ? req1_op  : req0_op;
        m_a   = m_id ? req1_a   : req0_a;
        m_b   = m_id ? req1_b   : req0_b;
        m_cin = m_id ? req1_cin : req0_cin;
        model_calc(m_op, m_a, m_b, m_cin, e_r, e_co, e_er, e_lat);
        busy   = 1'b1;
        acc_c  = cyc;
        m_last = c_ready[1];
        acc_ids.push_back(m_id);
        acc_cycs.push_back(cyc);
        acc_flag[m_id] = 1'b1;
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req_valid[0] = v;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req_valid[1] = v;
    end
  endtask

  task automatic rand_req(input int id, input logic v, input bit full_ops);
    logic [1:0] op;
    op = full_ops ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
    set_req(id, v, op, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_req_ready"},  32'(req_ready),  32'h0);
    check({nm, "_rsp_valid"},  32'(rsp_valid),  32'h0);
    check({nm, "_rsp_id"},     32'(rsp_id),     32'h0);
    check({nm, "_rsp_result"}, 32'(rsp_result), 32'h0);
    check({nm, "_rsp_cout"},   32'(rsp_cout),   32'h0);
    check({nm, "_rsp_err"},    32'(rsp_err),    32'h0);
    check({nm, "_alu_a"},      32'(alu_a),      32'h0);
    check({nm, "_alu_b"},      32'(alu_b),      32'h0);
    check({nm, "_alu_cin"},    32'(alu_cin),    32'h0);
    check({nm, "_alu_op"},     32'(alu_op),     32'h0);
  endtask

  // Single directed request checked against literal expectations
  task automatic do_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] er, input logic eco, input logic eer,
                        input int elat, input string nm);
    int ac;
    int lat;
    bit got;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_req(id, 1'b1, op, a, b, cin);
    got = 1'b0; ac = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1'b1; ac = cyc; end
    end
    if (!got) check({nm, "_accept_timeout"}, 32'h0, 32'h1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    got = 1'b0; lat = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        lat = cyc - ac;
        check({nm, "_latency"}, 32'(lat), 32'(elat));
        check({nm, "_id"},      32'(rsp_id),     32'(id));
        check({nm, "_result"},  32'(rsp_result), 32'(er));
        check({nm, "_cout"},    32'(rsp_cout),   32'(eco));
        check({nm, "_err"},     32'(rsp_err),    32'(eer));
      end
    end
    if (!got) check({nm, "_rsp_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  logic [7:0] p_r;
  logic       p_co, p_er;
  int         p_lat;
  int         n0, ac, hs;
  bit         got;
  logic [7:0] s_res;
  logic       s_id, s_co, s_er;

  initial begin
    // Pin the reference model with hand-computed vectors
    model_calc(2'b00, 8'hF0, 8'h20, 1'b1, p_r, p_co, p_er, p_lat);
    check("model_add", {20'h0, p_lat[3:0], p_co, p_er, 2'b00, p_r}, {20'h0, 4'd3, 1'b1, 1'b0, 2'b00, 8'h11});
    model_calc(2'b01, 8'h3C, 8'h00, 1'b1, p_r, p_co, p_er, p_lat);
    check("model_not", {20'h0, p_lat[3:0], p_co, p_er, 2'b00, p_r}, {20'h0, 4'd3, 1'b0, 1'b0, 2'b00, 8'hC3});
    model_calc(2'b11, 8'h12, 8'h34, 1'b0, p_r, p_co, p_er, p_lat);
    check("model_ill", {20'h0, p_lat[3:0], p_co, p_er, 2'b00, p_r}, {20'h0, 4'd1, 1'b0, 1'b1, 2'b00, 8'h00});

    // Reset: outputs at reset values even with both requests raised
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b11;
    #2 check_reset_vals("reset");
    req_valid = 2'b00;
    @(posedge clk); #3 rst_n = 1'b1;

    do_req(0, 2'b00, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0, 3, "add");
    if (SUB_EN) begin
      do_req(1, 2'b10, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 5, "sub_borrow");
      do_req(1, 2'b10, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0, 5, "sub_noborrow");
    end else begin
      do_req(1, 2'b10, 8'h05, 8'h07, 1'b1, 8'h00, 1'b0, 1'b1, 1, "sub_disabled");
      do_req(1, 2'b10, 8'h07, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1, "sub_disabled2");
    end
    do_req(0, 2'b01, 8'h5A, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 3, "not");

    // Re-establish last grant = 1 so the contention run starts with 0
    do_req(1, 2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 3, "add_r1");

    // Contention: both valid, grants alternate every 4 cycles
    @(posedge clk); #1;
    acc_flag[0] = 1'b0; acc_flag[1] = 1'b0;
    rsp_ready = 1'b1;
    n0 = acc_ids.size();
    rand_req(0, 1'b1, 1'b0);
    rand_req(1, 1'b1, 1'b0);
    repeat (40) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc_flag[i]) begin acc_flag[i] = 1'b0; rand_req(i, 1'b1, 1'b0); end
      end
    end
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    check("contention_count_ge8", 32'(acc_ids.size() - n0 >= 8), 32'h1);
    for (int k = n0; k < acc_ids.size(); k++)
      check("contention_order", 32'(acc_ids[k]), 32'((k - n0) % 2));
    for (int k = n0 + 1; k < acc_ids.size(); k++)
      check("contention_interval", 32'(acc_cycs[k] - acc_cycs[k-1]), 32'd4);

    // Backpressure: response held stable, no new accepts
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 2'b00, 8'h81, 8'h82, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); if (req_ready[0]) got = 1'b1; end
    if (!got) check("bp_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 2'b01, 8'h0F, 8'h00, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); if (rsp_valid) got = 1'b1; end
    if (!got) check("bp_rsp_timeout", 32'h0, 32'h1);
    s_res = rsp_result; s_id = rsp_id; s_co = rsp_cout; s_er = rsp_err;
    check("bp_result", 32'(s_res), 32'h03);
    check("bp_cout",   32'(s_co),  32'h1);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid",     32'(rsp_valid),  32'h1);
      check("bp_hold_res",  32'(rsp_result), 32'(s_res));
      check("bp_hold_id",   32'(rsp_id),     32'(s_id));
      check("bp_hold_cout", 32'(rsp_cout),   32'(s_co));
      check("bp_hold_err",  32'(rsp_err),    32'(s_er));
      check("bp_req_ready", 32'(req_ready),  32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    hs = cyc;
    got = 1'b0; ac = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin got = 1'b1; ac = cyc; end
    end
    if (!got) check("bp_next_timeout", 32'h0, 32'h1);
    check("bp_next_accept_cycle", 32'(ac - hs), 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (6) @(posedge clk);

    do_req(0, 2'b11, 8'h3C, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b1, 1, "illegal");

    // Reset mid-operation (CAPT2 when SUB is enabled)
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 2'b10, 8'h33, 8'h11, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); if (req_ready[1]) got = 1'b1; end
    if (!got) check("midrst_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_req(0, 2'b00, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3, "post_reset_add");

    // Randomized traffic with random backpressure
    acc_flag[0] = 1'b0; acc_flag[1] = 1'b0;
    repeat (1500) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc_flag[i] || !req_valid[i] || $urandom_range(0, 9) == 0) begin
          acc_flag[i] = 1'b0;
          rand_req(i, 1'($urandom_range(0, 9) < 4), 1'b1);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("random_accepts_seen", 32'(acc_ids.size() > 100), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_sequencer
